mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_pkg.sv | 23 ++
 rtl/mem_port_arbiter_rr_pick.sv | 44 ++++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_pkg.sv
// mem_port_pkg
//   Shared definitions for the PS/PL memory port arbiter: FSM state
//   encoding, default parameter values and a width helper.
package mem_port_pkg;

    // Arbiter FSM states. Two bits so the encoding can be observed directly.
    typedef enum logic [1:0] {
        PS_OWN   = 2'd0,   // processing system drives the memory port
        PL_RUN   = 2'd1,   // one PL channel owns the memory port
        HANDBACK = 2'd2    // one idle cycle while ownership returns to PS
    } state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_N_PL    = 2;
    localparam int DEF_TIMEOUT = 1024;

    // Index/counter width that never collapses to zero bits.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rr_pick
//   Round-robin first-set search. Starting at position ptr and wrapping
//   around, returns the index of the first set bit of req.
// Ports:
//   req   - request vector, one bit per channel
//   ptr   - search start position (0..N-1)
//   grant - index of the winning request (0 when none)
//   valid - high when any request bit is set
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] grant,
    output logic             valid
);

    logic             w_hit_hi;
    logic [PTR_W-1:0] w_hi_idx;
    logic [PTR_W-1:0] w_lo_idx;

    // Two descending scans so the lowest qualifying index is left in place:
    // the upper scan only sees bits at or above ptr, the lower scan sees all
    // bits and supplies the wrap-around winner when the upper scan is empty.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k] && (k >= int'(ptr))) begin
                w_hit_hi = 1'b1;
                w_hi_idx = PTR_W'(k);
            end
            if (req[k]) begin
                w_lo_idx = PTR_W'(k);
            end
        end
    end

    assign valid = |req;
    assign grant = w_hit_hi ? w_hi_idx : w_lo_idx;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between the processing system (PS) and N_PL
//   programmable-logic compute channels. PS owns the port by default; a PL
//   channel raising pl_ready is granted round-robin, keeps the port until it
//   finishes, drops ready, or runs TIMEOUT cycles, then one HANDBACK cycle
//   returns ownership to PS.
//
//   Handshake: pl_ready[k] is a level request. The grant is registered, so
//   pl_launch[k] rises one cycle after pl_ready[k] is sampled in PS_OWN and
//   stays high while channel k owns the port. The channel releases the port
//   by raising pl_finish[k] or lowering pl_ready[k]; either is acted on at
//   the next rising edge.
//
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   ps_we/ps_addr/ps_wdata        - PS memory request
//   pl_ready, pl_finish           - per-channel ownership request / done
//   pl_we/pl_addr/pl_wdata        - packed per-channel requests (ch k = slice k)
//   mem_we/mem_addr/mem_wdata     - memory port
//   pl_launch                     - one-hot grant to the owning channel
//   owner_ps                      - PS owns memory
//   timeout                       - pulse on counter-forced reclaim
//   ps_drop                       - pulse when a PS write is discarded
//   dbg_state                     - current FSM state
module mem_port_arbiter
    import mem_port_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int N_PL    = DEF_N_PL,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ps_we,
    input  logic [ADDR_W-1:0]        ps_addr,
    input  logic [DATA_W-1:0]        ps_wdata,
    input  logic [N_PL-1:0]          pl_ready,
    input  logic [N_PL-1:0]          pl_finish,
    input  logic [N_PL-1:0]          pl_we,
    input  logic [N_PL*ADDR_W-1:0]   pl_addr,
    input  logic [N_PL*DATA_W-1:0]   pl_wdata,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic [N_PL-1:0]          pl_launch,
    output logic                     owner_ps,
    output logic                     timeout,
    output logic                     ps_drop,
    output logic [1:0]               dbg_state
);

    localparam int GRANT_W = width_of(N_PL);
    localparam int CNT_W   = width_of(TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [GRANT_W-1:0] LAST_CH  = GRANT_W'(N_PL - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [GRANT_W-1:0] r_grant;
    logic [GRANT_W-1:0] r_rr_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic [GRANT_W-1:0] w_pick_idx;
    logic               w_pick_valid;

    logic               w_sel_we;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;
    logic               w_sel_finish;
    logic               w_sel_ready;
    logic [N_PL-1:0]    w_sel_onehot;

    rr_pick #(
        .N     (N_PL),
        .PTR_W (GRANT_W)
    ) u_rr_pick (
        .req   (pl_ready),
        .ptr   (r_rr_ptr),
        .grant (w_pick_idx),
        .valid (w_pick_valid)
    );

    // Granted channel's signals; only the owning slice can reach the port.
    always_comb begin
        w_sel_we     = 1'b0;
        w_sel_addr   = '0;
        w_sel_wdata  = '0;
        w_sel_finish = 1'b0;
        w_sel_ready  = 1'b0;
        w_sel_onehot = '0;
        for (int k = 0; k < N_PL; k++) begin
            if (r_grant == GRANT_W'(k)) begin
                w_sel_we        = pl_we[k];
                w_sel_addr      = pl_addr[k*ADDR_W +: ADDR_W];
                w_sel_wdata     = pl_wdata[k*DATA_W +: DATA_W];
                w_sel_finish    = pl_finish[k];
                w_sel_ready     = pl_ready[k];
                w_sel_onehot[k] = 1'b1;
            end
        end
    end

    // Next-state and port outputs.
    always_comb begin
        w_state_next = r_state;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        pl_launch    = '0;
        owner_ps     = 1'b0;
        timeout      = 1'b0;
        unique case (r_state)
            PS_OWN: begin
                mem_we    = ps_we;
                mem_addr  = ps_addr;
                mem_wdata = ps_wdata;
                owner_ps  = 1'b1;
                if (w_pick_valid) begin
                    w_state_next = PL_RUN;
                end
            end
            PL_RUN: begin
                mem_we    = w_sel_we;
                mem_addr  = w_sel_addr;
                mem_wdata = w_sel_wdata;
                pl_launch = w_sel_onehot;
                // Finish/abort win over the counter so a normal exit on the
                // last allowed cycle is not reported as a timeout.
                if (w_sel_finish || !w_sel_ready) begin
                    w_state_next = HANDBACK;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = HANDBACK;
                    timeout      = 1'b1;
                end
            end
            HANDBACK: begin
                w_state_next = PS_OWN;
            end
            default: begin
                w_state_next = PS_OWN;
            end
        endcase
    end

    assign ps_drop   = ps_we && (r_state != PS_OWN);
    assign dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= PS_OWN;
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == PS_OWN && w_pick_valid) begin
                r_grant  <= w_pick_idx;
                r_rr_ptr <= (w_pick_idx == LAST_CH) ? '0 : w_pick_idx + 1'b1;
                r_cnt    <= '0;
            end else if (r_state == PL_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_port_pkg::*;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NP = 2;
    localparam int TO = 16;

    logic            clk;
    logic            rst;
    logic            ps_we;
    logic [AW-1:0]   ps_addr;
    logic [DW-1:0]   ps_wdata;
    logic [NP-1:0]   pl_ready;
    logic [NP-1:0]   pl_finish;
    logic [NP-1:0]   pl_we;
    logic [NP*AW-1:0] pl_addr;
    logic [NP*DW-1:0] pl_wdata;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [NP-1:0]   pl_launch;
    logic            owner_ps;
    logic            timeout;
    logic            ps_drop;
    logic [1:0]      dbg_state;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .N_PL    (NP),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps_we     (ps_we),
        .ps_addr   (ps_addr),
        .ps_wdata  (ps_wdata),
        .pl_ready  (pl_ready),
        .pl_finish (pl_finish),
        .pl_we     (pl_we),
        .pl_addr   (pl_addr),
        .pl_wdata  (pl_wdata),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .pl_launch (pl_launch),
        .owner_ps  (owner_ps),
        .timeout   (timeout),
        .ps_drop   (ps_drop),
        .dbg_state (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pl(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pl_we[k]             = we;
        pl_addr[k*AW +: AW]  = a;
        pl_wdata[k*DW +: DW] = d;
    endtask

    task automatic chk_handback(input string tag);
        chk({tag, "_state"},  64'(dbg_state), 64'(HANDBACK));
        chk({tag, "_we"},     64'(mem_we),    64'd0);
        chk({tag, "_addr"},   64'(mem_addr),  64'd0);
        chk({tag, "_wdata"},  64'(mem_wdata), 64'd0);
        chk({tag, "_owner"},  64'(owner_ps),  64'd0);
        chk({tag, "_launch"}, 64'(pl_launch), 64'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        ps_we     = 1'b0;
        ps_addr   = '0;
        ps_wdata  = '0;
        pl_ready  = '0;
        pl_finish = '0;
        pl_we     = '0;
        pl_addr   = '0;
        pl_wdata  = '0;

        // Reset: PS owns memory even with a request pending.
        #2;
        pl_ready = 2'b11;
        step();
        chk("rst_state",   64'(dbg_state), 64'(PS_OWN));
        chk("rst_owner",   64'(owner_ps),  64'd1);
        chk("rst_launch",  64'(pl_launch), 64'd0);
        chk("rst_timeout", 64'(timeout),   64'd0);
        pl_ready = '0;
        step();
        rst = 1'b1;

        // PS pass-through in the same cycle.
        ps_we = 1'b1; ps_addr = 8'h01; ps_wdata = 32'hA5;
        #1;
        chk("ps_we",    64'(mem_we),    64'd1);
        chk("ps_addr",  64'(mem_addr),  64'h01);
        chk("ps_wdata", 64'(mem_wdata), 64'hA5);
        chk("ps_owner", 64'(owner_ps),  64'd1);
        chk("ps_nodrop",64'(ps_drop),   64'd0);
        ps_we = 1'b0;

        // Single grant to ch0, non-granted ch1 write must not leak.
        set_pl(0, 1'b1, 8'h02, 32'h0000_1111);
        set_pl(1, 1'b1, 8'h77, 32'h2222_0000);
        pl_ready = 2'b01;
        #1;
        chk("req_launch_wait", 64'(pl_launch), 64'd0);
        step();
        chk("g0_launch", 64'(pl_launch), 64'b01);
        chk("g0_owner",  64'(owner_ps),  64'd0);
        chk("g0_addr",   64'(mem_addr),  64'h02);
        chk("g0_wdata",  64'(mem_wdata), 64'h0000_1111);
        chk("g0_we",     64'(mem_we),    64'd1);
        pl_we = 2'b10;
        #1;
        chk("g0_ch1_we_blocked", 64'(mem_we), 64'd0);
        pl_we = 2'b01;
        ps_we = 1'b1; ps_wdata = 32'hDEAD_BEEF;
        #1;
        chk("drop_pulse", 64'(ps_drop),   64'd1);
        chk("drop_wdata", 64'(mem_wdata), 64'h0000_1111);
        ps_we = 1'b0;
        pl_finish = 2'b01;
        #1;
        chk("fin_no_timeout", 64'(timeout), 64'd0);
        step();
        pl_finish = '0;
        pl_ready  = '0;
        #1;
        chk_handback("hb0");
        ps_we = 1'b1;
        #1;
        chk("hb_drop", 64'(ps_drop), 64'd1);
        ps_we = 1'b0;
        step();
        chk("hb_back_owner", 64'(owner_ps),  64'd1);
        chk("hb_back_state", 64'(dbg_state), 64'(PS_OWN));

        // Fresh reset so the round-robin pointer starts at ch0.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        pl_ready = 2'b11;
        step();
        chk("rr1_launch", 64'(pl_launch), 64'b01);
        pl_finish = 2'b11;
        step();
        pl_finish = '0;
        chk("rr1_hb", 64'(dbg_state), 64'(HANDBACK));
        step();
        chk("rr1_ps", 64'(owner_ps), 64'd1);
        step();
        chk("rr2_launch", 64'(pl_launch), 64'b10);
        chk("rr2_addr",   64'(mem_addr),  64'h77);
        pl_finish = 2'b11;
        step();
        pl_finish = '0;
        step();
        step();
        chk("rr3_launch", 64'(pl_launch), 64'b01);
        // Abort: granted ch0 drops ready.
        pl_ready = 2'b10;
        #1;
        chk("abort_state", 64'(dbg_state), 64'(PL_RUN));
        step();
        pl_ready = '0;
        chk("abort_hb",      64'(dbg_state), 64'(HANDBACK));
        chk("abort_timeout", 64'(timeout),   64'd0);
        step();

        // Timeout: pointer is at ch1, only ch0 requests (wraps to ch0).
        pl_ready = 2'b01;
        step();
        chk("to_launch", 64'(pl_launch), 64'b01);
        for (int i = 1; i < TO; i++) begin
            chk($sformatf("to_quiet_%0d", i), 64'(timeout), 64'd0);
            step();
        end
        chk("to_pulse",    64'(timeout),   64'd1);
        chk("to_launch16", 64'(pl_launch), 64'b01);
        step();
        pl_ready = '0;
        chk("to_hb_timeout", 64'(timeout), 64'd0);
        chk_handback("to_hb");
        step();

        // Finish in the limit cycle: no timeout pulse.
        pl_ready = 2'b01;
        step();
        for (int i = 1; i < TO; i++) step();
        pl_finish = 2'b01;
        #1;
        chk("coin_timeout", 64'(timeout),   64'd0);
        chk("coin_launch",  64'(pl_launch), 64'b01);
        step();
        pl_finish = '0;
        pl_ready  = '0;
        chk("coin_hb", 64'(dbg_state), 64'(HANDBACK));
        step();

        // Reset mid-PL_RUN: PS owns the port before the next edge.
        pl_ready = 2'b01;
        step();
        chk("mid_launch", 64'(pl_launch), 64'b01);
        ps_addr = 8'h3C;
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_owner",  64'(owner_ps),  64'd1);
        chk("mid_rst_launch", 64'(pl_launch), 64'd0);
        chk("mid_rst_state",  64'(dbg_state), 64'(PS_OWN));
        chk("mid_rst_addr",   64'(mem_addr),  64'h3C);
        step();
        chk("mid_rst_hold", 64'(dbg_state), 64'(PS_OWN));
        rst = 1'b1;
        pl_ready = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
